// File: rtl/pif_arb_pkg.sv
// Shared types and constants for the PIF RAM arbiter family.
// Latency: n/a (types, constants and a pure grant-selection function).
// Backpressure: n/a.
package pif_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    // Read data returned to a requester whose access was aborted.
    localparam logic [7:0] ABORT_DATA = 8'hFF;

    // Pick the next owner. A lone requester always wins. On a tie the
    // requester that did not complete last wins, unless an unexpired
    // DMA lock holds the port for the DMA engine.
    function automatic logic [1:0] arb_pick(
        input logic       cpu_req,
        input logic       dma_req,
        input logic       lock_win,
        input logic [1:0] last_owner
    );
        logic [1:0] win;
        win = OWN_NONE;
        if (cpu_req && dma_req) begin
            if (lock_win || (last_owner == OWN_CPU)) begin
                win = OWN_DMA;
            end else begin
                win = OWN_CPU;
            end
        end else if (cpu_req) begin
            win = OWN_CPU;
        end else if (dma_req) begin
            win = OWN_DMA;
        end
        return win;
    endfunction

endpackage

// File: rtl/pif_ram_arbiter_if.sv
// Bundles the CPU, DMA and memory handshakes of the PIF RAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held until valid on each requester; mem_oe held until mem_valid.
// Ports: cpu_* / dma_* requester side, mem_* memory side, owner/timeout_err status.
// modport master: the arbiter. modport slave: the requesters plus the memory.
interface pif_ram_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_valid;

    logic              dma_req;
    logic              dma_lock;
    logic              dma_wr;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic [7:0]        dma_rdata;
    logic              dma_valid;

    logic              mem_oe;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_valid;

    logic [1:0]        owner;
    logic              timeout_err;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_valid,
        input  dma_req, dma_lock, dma_wr, dma_addr, dma_wdata,
        output dma_rdata, dma_valid,
        output mem_oe, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid,
        output owner, timeout_err
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_valid,
        output dma_req, dma_lock, dma_wr, dma_addr, dma_wdata,
        input  dma_rdata, dma_valid,
        input  mem_oe, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_valid,
        input  owner, timeout_err
    );

endinterface

// File: rtl/pif_arb_timeout.sv
// Loadable down-counter that flags when an access has waited TIMEOUT cycles.
// Latency: start loads TIMEOUT-1; expire is high in the TIMEOUT-th enabled cycle after start.
// Backpressure: none; the counter holds at zero until reloaded.
// Ports: clk, reset_l (sync, active-low), start (load), enable (count), expire (combinational).
module pif_arb_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_l,
    input  logic start,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/pif_ram_arbiter.sv
// Shares the 6502-side PIF RAM port between the CPU decode and the joybus DMA engine.
// Latency: grant at N, mem_oe at N+1, valid pulse one cycle after mem_valid (min N+2).
// Backpressure: requesters hold req until valid; a stalled memory is aborted after TIMEOUT cycles.
// Ports: clk, reset_l (sync, active-low), bus (master modport: cpu_*, dma_*, mem_*, owner, timeout_err).
module pif_ram_arbiter
    import pif_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset_l,
    pif_ram_arbiter_if.master  bus
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [1:0]        win;
    logic [1:0]        grant_q;
    logic [1:0]        last_owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        cpu_rdata_q;
    logic [7:0]        dma_rdata_q;
    logic              abort_q;

    // lock_q: dma_lock captured with the grant.
    // lock_prev_q: the last completion was a DMA access holding the lock.
    // locked_acc_q: the access in flight was granted through the lock.
    // burst_cnt_q counts completed lock-granted accesses, so a chain is the
    // round-robin grant that opened it plus at most MAX_BURST locked ones.
    logic              lock_q;
    logic              lock_prev_q;
    logic              locked_acc_q;
    logic [BW-1:0]     burst_cnt_q;

    logic              lock_win;
    logic              start;
    logic              done;
    logic              abort;
    logic              expire;
    logic              in_xfer;

    assign in_xfer  = (state_q == XFER);
    assign lock_win = lock_prev_q && (burst_cnt_q < BW'(MAX_BURST));

    pif_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_l (reset_l),
        .start   (start),
        .enable  (in_xfer),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        win             = OWN_NONE;
        start           = 1'b0;
        done            = 1'b0;
        abort           = 1'b0;

        bus.mem_oe      = in_xfer;
        bus.mem_wr      = in_xfer && wr_q;
        bus.mem_addr    = addr_q;
        bus.mem_wdata   = wdata_q;
        bus.cpu_valid   = (state_q == RESP) && (grant_q == OWN_CPU);
        bus.dma_valid   = (state_q == RESP) && (grant_q == OWN_DMA);
        bus.timeout_err = (state_q == RESP) && abort_q;
        bus.owner       = in_xfer ? grant_q : OWN_NONE;
        bus.cpu_rdata   = cpu_rdata_q;
        bus.dma_rdata   = dma_rdata_q;

        case (state_q)
            IDLE: begin
                win = arb_pick(bus.cpu_req, bus.dma_req, lock_win, last_owner_q);
                if (win != OWN_NONE) begin
                    start   = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                // A completion in the expiry cycle still wins over the abort.
                if (bus.mem_valid) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (expire) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            grant_q      <= OWN_NONE;
            last_owner_q <= OWN_DMA;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= 8'h00;
            cpu_rdata_q  <= 8'h00;
            dma_rdata_q  <= 8'h00;
            abort_q      <= 1'b0;
            lock_q       <= 1'b0;
            lock_prev_q  <= 1'b0;
            locked_acc_q <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            if (start) begin
                grant_q <= win;
                if (win == OWN_CPU) begin
                    addr_q       <= bus.cpu_addr;
                    wr_q         <= bus.cpu_wr;
                    wdata_q      <= bus.cpu_wdata;
                    lock_q       <= 1'b0;
                    locked_acc_q <= 1'b0;
                    burst_cnt_q  <= '0;
                end else begin
                    addr_q       <= bus.dma_addr;
                    wr_q         <= bus.dma_wr;
                    wdata_q      <= bus.dma_wdata;
                    lock_q       <= bus.dma_lock;
                    locked_acc_q <= lock_win;
                end
            end

            if (done || abort) begin
                abort_q <= abort;
                if (!wr_q) begin
                    if (grant_q == OWN_CPU) begin
                        cpu_rdata_q <= abort ? ABORT_DATA : bus.mem_rdata;
                    end else begin
                        dma_rdata_q <= abort ? ABORT_DATA : bus.mem_rdata;
                    end
                end
            end

            if (state_q == RESP) begin
                last_owner_q <= grant_q;
                if ((grant_q == OWN_DMA) && lock_q) begin
                    lock_prev_q <= 1'b1;
                    if (locked_acc_q) begin
                        burst_cnt_q <= burst_cnt_q + BW'(1);
                    end
                end else begin
                    lock_prev_q <= 1'b0;
                    if (grant_q == OWN_DMA) begin
                        burst_cnt_q <= '0;
                    end
                end
            end
        end
    end

endmodule
